// File: rtl/rr_arbiter_4way.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4way
//   Round-robin arbiter that shares one resource among four requesters. The
//   grant is a registered one-hot enable plus a 2-bit owner index. The grant is
//   held until one of three things happens: the owner releases it, the owner
//   drops its request, or the optional hold limit expires. After every grant
//   there is exactly one idle turnaround cycle (GAP) before the next owner.
//
// Parameters
//   MAX_HOLD       maximum consecutive BUSY cycles per grant (0 = unlimited)
//   CNT_W          hold-counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clock_i        rising-edge clock
//   reset_n_i      synchronous reset, active low
//   req_i[3:0]     level request per requester, held until served
//   release_i      owner finished; only looked at while BUSY
//   grant_o[3:0]   one-hot grant, 4'b0000 when nobody owns the resource
//   grant_idx_o    index of the owner, meaningful only when grant_valid_o=1
//   grant_valid_o  high exactly while a grant is active (state BUSY)
//   timeout_o      one-cycle pulse: grant was revoked by the hold limit alone
// -----------------------------------------------------------------------------
module rr_arbiter_4way #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [3:0] req_i,
    input  logic       release_i,
    output logic [3:0] grant_o,
    output logic [1:0] grant_idx_o,
    output logic       grant_valid_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter value seen in the last allowed BUSY cycle. Unused when the
    // limit is disabled, but kept well defined so the compare never wraps.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q,       state_d;
    logic [3:0]       grant_q,       grant_d;
    logic [1:0]       grant_idx_q,   grant_idx_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q,     timeout_d;
    logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic [1:0]       last_q,        last_d;

    logic [2:0]       pick;          // {found, index}
    logic             owner_done;
    logic             limit_hit;

    // Search last+1, last+2, last+3, last (mod 4); the first hit wins. The loop
    // runs from the lowest priority upward so the highest-priority hit is the
    // one left standing. 2'(4) wraps to 0, giving the "last" slot.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick       = rr_pick(req_i, last_q);
        owner_done = release_i || !req_i[grant_idx_q];
        limit_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        last_d        = last_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;

        case (state_q)
            // IDLE and GAP arbitrate identically; GAP exists only so that the
            // previous owner's grant is guaranteed to be low for one cycle.
            ST_IDLE, ST_GAP: begin
                if (pick[2]) begin
                    state_d     = ST_BUSY;
                    grant_d     = 4'b0001 << pick[1:0];
                    grant_idx_d = pick[1:0];
                    hold_cnt_d  = '0;
                end else begin
                    state_d     = ST_IDLE;
                    grant_d     = 4'b0000;
                end
            end

            ST_BUSY: begin
                if (owner_done || limit_hit) begin
                    state_d   = ST_GAP;
                    grant_d   = 4'b0000;
                    last_d    = grant_idx_q;
                    // A voluntary exit in the same cycle masks the timeout.
                    timeout_d = limit_hit && !owner_done;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        grant_valid_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
            last_q        <= 2'd3;   // requester 0 is first in line
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
            last_q        <= last_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = grant_idx_q;
    assign grant_valid_o = grant_valid_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4way.sv
module tb_rr_arbiter_4way;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    // Second instance with a one-cycle hold limit, driven independently.
    logic       rst1_n;
    logic [3:0] req1;
    logic       rel1;
    logic [3:0] grant1;
    logic [1:0] grant1_idx;
    logic       grant1_valid;
    logic       timeout1;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_4way #(.MAX_HOLD(16), .CNT_W(5)) u_dut (
        .clock_i       (clk),
        .reset_n_i     (rst_n),
        .req_i         (req),
        .release_i     (rel),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .timeout_o     (timeout)
    );

    rr_arbiter_4way #(.MAX_HOLD(1), .CNT_W(2)) u_dut1 (
        .clock_i       (clk),
        .reset_n_i     (rst1_n),
        .req_i         (req1),
        .release_i     (rel1),
        .grant_o       (grant1),
        .grant_idx_o   (grant1_idx),
        .grant_valid_o (grant1_valid),
        .timeout_o     (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rel;
        logic [3:0] g;
        logic [1:0] idx;
        logic       t;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic l,
                                input logic [3:0] g, input logic [1:0] i,
                                input logic t);
        vec_t v;
        v.rst_n = r; v.req = q; v.rel = l; v.g = g; v.idx = i; v.t = t;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, step, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge, outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input int step, input logic [3:0] g,
                            input logic [1:0] i, input logic t);
        chk({tag, "_grant"}, step, 32'(grant), 32'(g));
        chk({tag, "_valid"}, step, 32'(grant_valid), 32'(|g));
        chk({tag, "_timeout"}, step, 32'(timeout), 32'(t));
        if (|g) chk({tag, "_idx"}, step, 32'(grant_idx), 32'(i));
    endtask

    task automatic chk_one(input string tag, input int step, input logic [3:0] g,
                           input logic [1:0] i, input logic t);
        chk({tag, "_grant"}, step, 32'(grant1), 32'(g));
        chk({tag, "_valid"}, step, 32'(grant1_valid), 32'(|g));
        chk({tag, "_timeout"}, step, 32'(timeout1), 32'(t));
        if (|g) chk({tag, "_idx"}, step, 32'(grant1_idx), 32'(i));
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; rel = 1'b0;
        rst1_n = 1'b0; req1 = 4'b0000; rel1 = 1'b0;

        // rst, req, rel -> grant, idx, timeout (after the following edge)
        // Reset with all requesting, then rotation with release every BUSY cycle.
        add(0, 4'b1111, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 4'b0001, 0, 0);
        add(1, 4'b1111, 1, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 4'b0010, 1, 0);
        add(1, 4'b1111, 1, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 4'b0100, 2, 0);
        add(1, 4'b1111, 1, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 4'b1000, 3, 0);
        add(1, 4'b1111, 1, 4'b0000, 0, 0);
        // Single requester 2, release after three BUSY cycles, then idle.
        add(1, 4'b0100, 0, 4'b0100, 2, 0);
        add(1, 4'b0100, 0, 4'b0100, 2, 0);
        add(1, 4'b0100, 0, 4'b0100, 2, 0);
        add(1, 4'b0100, 1, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 1, 4'b0000, 0, 0);   // release in IDLE ignored
        // Owner 1 drops its request while 3 waits: gap, then 3, no timeout.
        add(1, 4'b0010, 0, 4'b0010, 1, 0);
        add(1, 4'b0010, 0, 4'b0010, 1, 0);
        add(1, 4'b1000, 0, 4'b0000, 0, 0);
        add(1, 4'b1000, 0, 4'b1000, 3, 0);
        add(1, 4'b1000, 1, 4'b0000, 0, 0);
        // Reset while 1 owns; afterwards requester 0 wins first.
        add(1, 4'b0010, 0, 4'b0010, 1, 0);
        add(0, 4'b0011, 0, 4'b0000, 0, 0);
        add(1, 4'b0011, 0, 4'b0001, 0, 0);
        add(1, 4'b0011, 1, 4'b0000, 0, 0);
        add(1, 4'b0011, 0, 4'b0010, 1, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        // A non-owner raising its request mid-grant changes nothing.
        add(1, 4'b0001, 0, 4'b0001, 0, 0);
        add(1, 4'b1001, 0, 4'b0001, 0, 0);
        add(1, 4'b1001, 1, 4'b0000, 0, 0);
        add(1, 4'b1001, 0, 4'b1000, 3, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);

        foreach (vecs[n]) begin
            rst_n = vecs[n].rst_n;
            req   = vecs[n].req;
            rel   = vecs[n].rel;
            tick();
            chk_main("vec", n, vecs[n].g, vecs[n].idx, vecs[n].t);
            $display("vec %0d rst_n=%0b req=%b rel=%0b -> grant=%b idx=%0d valid=%0b timeout=%0b",
                     n, rst_n, req, rel, grant, grant_idx, grant_valid, timeout);
        end

        // Hold limit: requester 0 alone, no release (last=3 from table end).
        req = 4'b0001; rel = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk_main("hold", k, 4'b0001, 0, 0);
        end
        tick();
        chk_main("hold_expire", 17, 4'b0000, 0, 1);
        tick();
        chk_main("hold_regrant", 18, 4'b0001, 0, 0);
        $display("hold-limit sequence done grant=%b timeout=%0b", grant, timeout);
        req = 4'b0000;
        tick();
        chk_main("hold_drop", 19, 4'b0000, 0, 0);
        tick();
        chk_main("hold_idle", 20, 4'b0000, 0, 0);

        // Release coincides with the hold limit: no timeout, normal handover.
        req = 4'b0011; rel = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk_main("tie", k, 4'b0010, 1, 0);
        end
        rel = 1'b1;
        tick();
        chk_main("tie_release", 17, 4'b0000, 0, 0);
        rel = 1'b0;
        tick();
        chk_main("tie_handover", 18, 4'b0001, 0, 0);
        $display("release/limit tie sequence done grant=%b timeout=%0b", grant, timeout);
        req = 4'b0000;
        tick();
        chk_main("tie_drop", 19, 4'b0000, 0, 0);

        // MAX_HOLD=1 instance: each grant lasts one cycle.
        tick();
        chk_one("mh1_reset", 0, 4'b0000, 0, 0);
        rst1_n = 1'b1; req1 = 4'b0001;
        tick();
        chk_one("mh1_grant", 1, 4'b0001, 0, 0);
        tick();
        chk_one("mh1_expire", 2, 4'b0000, 0, 1);
        tick();
        chk_one("mh1_regrant", 3, 4'b0001, 0, 0);
        rel1 = 1'b1;
        tick();
        chk_one("mh1_release", 4, 4'b0000, 0, 0);
        rel1 = 1'b0; req1 = 4'b0110;
        tick();
        chk_one("mh1_next", 5, 4'b0010, 1, 0);
        tick();
        chk_one("mh1_expire2", 6, 4'b0000, 0, 1);
        tick();
        chk_one("mh1_rotate", 7, 4'b0100, 2, 0);
        $display("max_hold=1 sequence done grant=%b timeout=%0b", grant1, timeout1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
